traffic_phase_timer: RTL and testbench
======================================

Name: traffic_phase_timer

Overview:
- Upstream pacing stage for the RGB traffic-light sequencer.
- Counts a programmable dwell time per phase (RED, GREEN, YELLOW) and issues a one-cycle Advance strobe when the current phase expires; the sequencer steps its state only on that strobe.
- Mirrors the sequencer's phase order internally. Accepts a pedestrian request that shortens the GREEN dwell.

Parameters:
- CNT_W, 8, width of the dwell counter.
- RED_TICKS, 10, RED dwell in enabled ticks; range 1 to 2^CNT_W.
- GREEN_TICKS, 8, GREEN dwell in enabled ticks; range 1 to 2^CNT_W.
- YELLOW_TICKS, 3, YELLOW dwell in enabled ticks; range 1 to 2^CNT_W.
- MIN_GREEN, 2, minimum remaining GREEN ticks after a pedestrian request; range 1 to GREEN_TICKS.

Ports:
- Clock  input  1  system clock; all logic on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- Enable  input  1  tick qualifier (e.g. 1 Hz strobe); the counter moves only when Enable=1.
- Ped_Req  input  1  pedestrian button, level or pulse; latched.
- Advance  output  1  registered, one-cycle strobe to the downstream sequencer.
- Phase  output  2  current phase: 0=RED, 1=GREEN, 2=YELLOW.
- Remaining  output  CNT_W  ticks left in the current phase, minus one.
- Ped_Pending  output  1  latched pedestrian request not yet served.

Behaviour:
- Clock port is Clock; reset port is Reset. Reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - Phase=0 (RED)
  - Remaining=RED_TICKS-1
  - Advance=0
  - Ped_Pending=0
- Reset mid-phase discards any count and any pending request.
- Phase order: RED -> GREEN -> YELLOW -> RED. This matches the downstream S0 -> S1 -> S2 order.
- Illegal Phase=3 recovers to RED on the next edge, with Remaining=RED_TICKS-1 and Advance=1, so the downstream resynchronises.
- Counting:
  - Enable=0: Remaining and Phase hold; Advance=0 on the next edge.
  - Enable=1 and Remaining>0: Remaining decrements by 1.
  - Enable=1 and Remaining==0: on the next edge Phase moves to the next phase, Remaining loads that phase's TICKS-1, and Advance=1 for exactly one cycle.
- Timing: a phase lasts exactly its TICKS enabled cycles. Advance is coincident with the new Phase value. Latency from the terminal tick to Advance is 1 clock.
- Pedestrian request:
  - Ped_Pending sets on any cycle with Ped_Req=1.
  - It clears on the edge that enters RED from YELLOW. If Ped_Req=1 on that same cycle, the set wins and Ped_Pending stays 1.
  - While Phase=GREEN and Ped_Pending=1 and Remaining>MIN_GREEN-1, Remaining loads MIN_GREEN-1. This happens once, independent of Enable. It is then counted down normally.
  - Truncation never lengthens GREEN.
  - A request arriving in RED or YELLOW is held and shortens the next GREEN.
- If truncation and the terminal count occur in the same cycle, the terminal-count transition takes priority.
- Arithmetic: unsigned, CNT_W bits. The counter never wraps below 0.

Optional Feature:
- Macro PED_REQUEST_EN.
- Defined: pedestrian latching and GREEN truncation as described above.
- Undefined: Ped_Req is ignored, Ped_Pending is tied to 0, and GREEN always lasts GREEN_TICKS. Port list is unchanged.

Decomposition:
- Shared package holds:
  - phase encodings PH_RED=0, PH_GREEN=1, PH_YELLOW=2, reused by the sequencer
  - the RGB one-hot constants
  - a 2-bit phase typedef
- One natural sub-module: phase_dwell_counter. It is a loadable down-counter with an Enable input, a load input and value, and a terminal-count flag. The top level holds the phase FSM and the pedestrian latch.

Test Plan:
- Reset, then Enable held at 1, defaults: Advance pulses at Enable-cycles 10, 18, 21, 31. Phase goes 1, 2, 0, 1 at those pulses.
- Enable toggling 1-of-4 cycles: dwell durations in clocks are 40, 32, 12. Advance width is always 1 clock.
- Ped_Req pulse at GREEN with Remaining=6 (PED_REQUEST_EN defined): next cycle Remaining=1, Advance follows 2 ticks later. Ped_Pending clears on entry to RED.
- Ped_Req during RED: Ped_Pending=1. The following GREEN lasts MIN_GREEN=2 ticks. Without PED_REQUEST_EN, GREEN lasts 8 ticks and Ped_Pending stays 0.
- Reset asserted mid-GREEN with Ped_Pending=1: next edge gives Phase=0, Remaining=9, Ped_Pending=0, Advance=0.
- Force Phase=3 (via hierarchical deposit): next edge gives Phase=0, Remaining=9, Advance=1.

Source files
------------

// File: rtl/traffic_phase_timer_pkg.sv
// Shared phase encodings and lamp constants for the traffic-light pacing timer and sequencer.
// Phase order RED -> GREEN -> YELLOW matches the sequencer's S0 -> S1 -> S2.
package traffic_phase_timer_pkg;

    typedef enum logic [1:0] {
        PH_RED    = 2'd0,
        PH_GREEN  = 2'd1,
        PH_YELLOW = 2'd2
    } phase_t;

    // One-hot lamp drive, bit order {R, G, B}
    localparam logic [2:0] RGB_RED   = 3'b100;
    localparam logic [2:0] RGB_GREEN = 3'b010;
    localparam logic [2:0] RGB_BLUE  = 3'b001;

    function automatic phase_t next_phase(input phase_t p);
        case (p)
            PH_RED:   next_phase = PH_GREEN;
            PH_GREEN: next_phase = PH_YELLOW;
            default:  next_phase = PH_RED;
        endcase
    endfunction

endpackage

// File: rtl/traffic_phase_timer_dwell.sv
// phase_dwell_counter: loadable down-counter that holds at zero; load beats decrement.
// tc_o flags a zero count so the owner can act on the next enabled tick.
module phase_dwell_counter #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    output logic [CNT_W-1:0] count_o,
    output logic             tc_o
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i)
            count_d = load_val_i;
        else if (en_i && count_q != '0)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) count_q <= RST_VAL;
        else       count_q <= count_d;
    end

    assign count_o = count_q;
    assign tc_o    = (count_q == '0);

endmodule

// File: rtl/traffic_phase_timer.sv
// Phase pacing timer: counts per-phase dwell and strobes Advance when a phase expires.
// Define PED_REQUEST_EN to enable pedestrian latching and GREEN truncation.
module traffic_phase_timer
    import traffic_phase_timer_pkg::*;
#(
    parameter int CNT_W        = 8,
    parameter int RED_TICKS    = 10,
    parameter int GREEN_TICKS  = 8,
    parameter int YELLOW_TICKS = 3,
    parameter int MIN_GREEN    = 2
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             Enable,
    input  logic             Ped_Req,
    output logic             Advance,
    output logic [1:0]       Phase,
    output logic [CNT_W-1:0] Remaining,
    output logic             Ped_Pending
);

    localparam logic [CNT_W-1:0] RED_M1    = CNT_W'(RED_TICKS - 1);
    localparam logic [CNT_W-1:0] GREEN_M1  = CNT_W'(GREEN_TICKS - 1);
    localparam logic [CNT_W-1:0] YELLOW_M1 = CNT_W'(YELLOW_TICKS - 1);
    localparam logic [CNT_W-1:0] MIN_M1    = CNT_W'(MIN_GREEN - 1);

    phase_t           phase_q, phase_d;
    logic             adv_q, adv_d;
    logic             ped_q, ped_d;
    logic             ld;
    logic [CNT_W-1:0] ld_val;
    logic [CNT_W-1:0] cnt;
    logic             tc;
    logic             ped_now;

`ifdef PED_REQUEST_EN
    assign ped_now = ped_q | Ped_Req;
`else
    logic unused_ped_req;
    assign unused_ped_req = Ped_Req;
    assign ped_now        = 1'b0;
`endif

    always_comb begin
        phase_d = phase_q;
        adv_d   = 1'b0;
        ld      = 1'b0;
        ld_val  = RED_M1;
        ped_d   = ped_now;
        case (phase_q)
            PH_RED, PH_GREEN, PH_YELLOW: begin
                if (Enable && tc) begin
                    phase_d = next_phase(phase_q);
                    adv_d   = 1'b1;
                    ld      = 1'b1;
                    case (phase_q)
                        // a request already pending shortens GREEN from its very first tick
                        PH_RED:   ld_val = ped_now ? MIN_M1 : GREEN_M1;
                        PH_GREEN: ld_val = YELLOW_M1;
                        default: begin
                            ld_val = RED_M1;
`ifdef PED_REQUEST_EN
                            ped_d  = Ped_Req;
`endif
                        end
                    endcase
                end else if (phase_q == PH_GREEN && ped_now && cnt > MIN_M1) begin
                    ld     = 1'b1;
                    ld_val = MIN_M1;
                end
            end
            default: begin
                // unreachable encoding: force RED and strobe so the sequencer resyncs
                phase_d = PH_RED;
                adv_d   = 1'b1;
                ld      = 1'b1;
                ld_val  = RED_M1;
            end
        endcase
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            phase_q <= PH_RED;
            adv_q   <= 1'b0;
            ped_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            adv_q   <= adv_d;
            ped_q   <= ped_d;
        end
    end

    phase_dwell_counter #(
        .CNT_W   (CNT_W),
        .RST_VAL (RED_M1)
    ) u_dwell (
        .clk_i      (Clock),
        .rst_i      (Reset),
        .en_i       (Enable),
        .load_i     (ld),
        .load_val_i (ld_val),
        .count_o    (cnt),
        .tc_o       (tc)
    );

    assign Advance     = adv_q;
    assign Phase       = phase_q;
    assign Remaining   = cnt;
    assign Ped_Pending = ped_q;

endmodule

// File: tb/tb_traffic_phase_timer.sv
// Directed bench for traffic_phase_timer: per-cycle scoreboard against a behavioural model
// plus fixed-value checks of dwell timing, pedestrian truncation, reset and illegal-phase recovery.
module tb_traffic_phase_timer;
    import traffic_phase_timer_pkg::*;

`ifdef PED_REQUEST_EN
    localparam bit PED = 1'b1;
`else
    localparam bit PED = 1'b0;
`endif

    localparam logic [7:0] RT_M1 = 8'd9;
    localparam logic [7:0] GT_M1 = 8'd7;
    localparam logic [7:0] YT_M1 = 8'd2;
    localparam logic [7:0] MG_M1 = 8'd1;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic       Enable = 1'b0;
    logic       Ped_Req = 1'b0;
    logic       Advance;
    logic [1:0] Phase;
    logic [7:0] Remaining;
    logic       Ped_Pending;

    traffic_phase_timer dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .Enable      (Enable),
        .Ped_Req     (Ped_Req),
        .Advance     (Advance),
        .Phase       (Phase),
        .Remaining   (Remaining),
        .Ped_Pending (Ped_Pending)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [1:0] ph;
        logic [7:0] rem;
        logic       adv;
        logic       ped;
    } exp_t;

    exp_t       sbq[$];
    logic [1:0] m_ph  = 2'd0;
    logic [7:0] m_rem = 8'd9;
    logic       m_ped = 1'b0;
    int         nerr = 0;
    int         nchk = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one clock of stimulus, push the model's prediction, then compare after the edge.
    task automatic step(input logic rst, input logic en, input logic pr);
        exp_t       e;
        logic       pend;
        logic [1:0] nph;
        logic [7:0] nrem;
        logic       nadv, nped;
        @(negedge Clock);
        Reset = rst; Enable = en; Ped_Req = pr;
        pend = PED && (m_ped || pr);
        nph = m_ph; nrem = m_rem; nadv = 1'b0; nped = pend;
        if (rst) begin
            nph = 2'd0; nrem = RT_M1; nped = 1'b0;
        end else if (m_ph == 2'd3) begin
            nph = 2'd0; nrem = RT_M1; nadv = 1'b1;
        end else if (en && m_rem == 8'd0) begin
            nadv = 1'b1;
            if (m_ph == 2'd0) begin
                nph = 2'd1; nrem = pend ? MG_M1 : GT_M1;
            end else if (m_ph == 2'd1) begin
                nph = 2'd2; nrem = YT_M1;
            end else begin
                nph = 2'd0; nrem = RT_M1; nped = PED && pr;
            end
        end else if (m_ph == 2'd1 && pend && m_rem > MG_M1) begin
            nrem = MG_M1;
        end else if (en && m_rem != 8'd0) begin
            nrem = m_rem - 8'd1;
        end
        m_ph = nph; m_rem = nrem; m_ped = nped;
        e.ph = nph; e.rem = nrem; e.adv = nadv; e.ped = nped;
        sbq.push_back(e);
        @(posedge Clock);
        #1;
        e = sbq.pop_front();
        chk("sb_phase", 32'(Phase), 32'(e.ph));
        chk("sb_remaining", 32'(Remaining), 32'(e.rem));
        chk("sb_advance", 32'(Advance), 32'(e.adv));
        chk("sb_ped_pending", 32'(Ped_Pending), 32'(e.ped));
    endtask

    initial begin
        int at1[4] = '{10, 18, 21, 31};
        int ph1[4] = '{1, 2, 0, 1};
        int t2[4]  = '{0, 0, 0, 0};
        int na, n, wide;
        logic prev;

        // reset state
        step(1'b1, 1'b0, 1'b0);
        chk("rst_phase", 32'(Phase), 32'd0);
        chk("rst_remaining", 32'(Remaining), 32'd9);
        chk("rst_advance", 32'(Advance), 32'd0);
        chk("rst_ped", 32'(Ped_Pending), 32'd0);

        // Enable held high: Advance at enabled cycles 10, 18, 21, 31
        na = 0;
        for (int e = 1; e <= 31; e++) begin
            step(1'b0, 1'b1, 1'b0);
            if (Advance) begin
                if (na < 4) begin
                    chk("t1_adv_cycle", 32'(e), 32'(at1[na]));
                    chk("t1_adv_phase", 32'(Phase), 32'(ph1[na]));
                end
                na++;
            end
        end
        chk("t1_adv_count", 32'(na), 32'd4);

        // Enable 1-of-4: dwell in clocks GREEN 32, YELLOW 12, RED 40
        step(1'b1, 1'b0, 1'b0);
        na = 0; wide = 0; prev = 1'b0;
        for (int i = 0; i < 200 && na < 4; i++) begin
            step(1'b0, (i % 4) == 3, 1'b0);
            if (Advance && prev) wide++;
            if (Advance) begin t2[na] = i; na++; end
            prev = Advance;
        end
        step(1'b0, 1'b0, 1'b0);
        chk("t2_adv_after_pulse", 32'(Advance), 32'd0);
        chk("t2_adv_count", 32'(na), 32'd4);
        chk("t2_adv_wide", 32'(wide), 32'd0);
        chk("t2_green_clocks", 32'(t2[1] - t2[0]), 32'd32);
        chk("t2_yellow_clocks", 32'(t2[2] - t2[1]), 32'd12);
        chk("t2_red_clocks", 32'(t2[3] - t2[2]), 32'd40);

        // pedestrian pulse in GREEN with Remaining=6
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 40 && !(Phase == 2'd1 && Remaining == 8'd6); i++)
            step(1'b0, 1'b1, 1'b0);
        chk("t3_green_rem6", 32'(Phase == 2'd1 && Remaining == 8'd6), 32'd1);
        step(1'b0, 1'b1, 1'b1);
        chk("t3_rem_after_req", 32'(Remaining), PED ? 32'd1 : 32'd5);
        chk("t3_ped_set", 32'(Ped_Pending), PED ? 32'd1 : 32'd0);
        n = 0;
        do begin step(1'b0, 1'b1, 1'b0); n++; end while (!Advance && n < 20);
        chk("t3_ticks_to_adv", 32'(n), PED ? 32'd2 : 32'd6);
        chk("t3_yellow", 32'(Phase), 32'd2);
        chk("t3_ped_in_yellow", 32'(Ped_Pending), PED ? 32'd1 : 32'd0);
        n = 0;
        do begin step(1'b0, 1'b1, 1'b0); n++; end while (!Advance && n < 20);
        chk("t3_red_entry", 32'(Phase), 32'd0);
        chk("t3_ped_cleared", 32'(Ped_Pending), 32'd0);

        // request during RED shortens the following GREEN
        step(1'b0, 1'b1, 1'b1);
        chk("t4_ped_latched", 32'(Ped_Pending), PED ? 32'd1 : 32'd0);
        n = 0;
        do begin step(1'b0, 1'b1, 1'b0); n++; end while (!Advance && n < 30);
        chk("t4_green_entry", 32'(Phase), 32'd1);
        chk("t4_green_load", 32'(Remaining), PED ? 32'd1 : 32'd7);
        n = 0;
        do begin step(1'b0, 1'b1, 1'b0); n++; end while (!Advance && n < 30);
        chk("t4_green_ticks", 32'(n), PED ? 32'd2 : 32'd8);

        // reset mid-GREEN with a pending request
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        chk("t5_ped_before_rst", 32'(Ped_Pending), PED ? 32'd1 : 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("t5_phase", 32'(Phase), 32'd0);
        chk("t5_remaining", 32'(Remaining), 32'd9);
        chk("t5_ped", 32'(Ped_Pending), 32'd0);
        chk("t5_advance", 32'(Advance), 32'd0);

        // illegal phase recovers to RED with a resync strobe
        step(1'b0, 1'b1, 1'b0);
        force dut.phase_q = phase_t'(2'd3);
        #1;
        release dut.phase_q;
        m_ph = 2'd3;
        chk("t6_forced", 32'(Phase), 32'd3);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_phase", 32'(Phase), 32'd0);
        chk("t6_remaining", 32'(Remaining), 32'd9);
        chk("t6_advance", 32'(Advance), 32'd1);
        step(1'b0, 1'b0, 1'b0);
        chk("t6_adv_single", 32'(Advance), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
